psum_accumulator: RTL and testbench
===================================

Name: psum_accumulator

Overview:
- Read-modify-write stage directly upstream of the conv output buffer; pairs with it in a loop.
- Takes 8-lane MAC results per beat and reads the matching partial sum from the buffer (adder_pulse / adder_feature).
- Adds the two per lane with saturation and writes the result back to the buffer (feature_out / feature_valid_out).
- On the last input-channel pass, emits final sums downstream instead of writing back.

Parameters:
- MAC_OUTPUT_WIDTH, `MAC_OUTPUT_WIDTH (36): signed width of one lane.
- LANES, 8: lanes per beat.
- READ_LATENCY, 3: cycles from the adder_pulse cycle to the matching adder_feature being valid.

Ports:
- system_clk  in  1  clock
- rst_n  in  1  reset
- pass_start  in  1  pulse; a new accumulation pass begins
- mac_data  in  MAC_OUTPUT_WIDTH*LANES  MAC lanes, lane i at [i*W +: W]
- mac_valid  in  1  beat strobe
- pass_first  in  1  beat is from the first pass (no read-back); qualified by mac_valid
- pass_last  in  1  beat is from the last pass (emit final); qualified by mac_valid
- ready  out  1  beats accepted only when high
- refresh_req  out  1  resets buffer read/write addresses
- adder_pulse  out  1  buffer read advance
- adder_feature  in  MAC_OUTPUT_WIDTH*LANES  buffer read data
- feature_out  out  MAC_OUTPUT_WIDTH*LANES  write-back data
- feature_valid_out  out  1  write-back strobe
- final_data  out  MAC_OUTPUT_WIDTH*LANES  completed sums
- final_valid  out  1  completed-sum strobe
- sat_flag  out  1  sticky saturation indicator
- drop_flag  out  1  sticky: beat arrived while ready low

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock system_clk.
- Reset values: every output is 0; FSM is in ACCEPT; the pipeline holds no valid beats.
- FSM states: ACCEPT (ready=1), DRAIN (ready=0), REFRESH (ready=0, refresh_req=1 for exactly one cycle).
- ACCEPT + pass_start:
  - Goes to REFRESH if the pipeline is empty and mac_valid=0 that cycle; otherwise goes to DRAIN.
  - A mac_valid in the same cycle as pass_start belongs to the old pass and is accepted.
- DRAIN -> REFRESH once all in-flight beats have retired.
- REFRESH -> ACCEPT after one cycle.
- pass_start outside ACCEPT is ignored.
- Accepted beat = mac_valid & ready.
- adder_pulse is combinational: accepted & ~pass_first, in the same cycle t.
- Every accepted beat (first pass or not) enters a READ_LATENCY-deep delay line carrying data, pass_first and pass_last. This keeps uniform ordering.
- At cycle t+READ_LATENCY, per lane:
  - pass_first: sum = mac lane.
  - otherwise: sum = signed mac lane + signed adder_feature lane, computed in W+1 bits.
  - Saturate to [-2^(W-1), 2^(W-1)-1]; saturation sets sat_flag.
- The result is registered; outputs are valid at t+READ_LATENCY+1 (latency 4 by default).
- Output routing:
  - pass_last=0: feature_out/feature_valid_out, one write per accepted beat, in acceptance order.
  - pass_last=1: final_data/final_valid; no buffer write.
- pass_first & pass_last on one beat: no read, final output of mac data directly.
- Back-to-back beats every cycle are supported; throughput is 1 beat/cycle.
- Read of address k always precedes the write of address k (latency 4 > 0), so no hazard.
- mac_valid while ready=0: beat discarded, drop_flag set, no adder_pulse.
- sat_flag and drop_flag clear only on rst_n or when entering REFRESH.
- Data outputs hold their last value when their strobe is low.
- Asserting rst_n mid-pass: all in-flight beats are lost, and no strobe is emitted afterwards.

Decomposition:
- Shared parameters file: MAC_OUTPUT_WIDTH, LANES, BUFFER_READ_LATENCY (equal to the buffer's read latency), and saturation max/min constants.
- One sub-module, psum_sat_add: a single lane of signed add plus saturate, with sat output. It is instantiated LANES times in a generate.
- The FSM, delay line and flags live in the top module.

Test Plan:
- Reset, then pass_start with an empty pipe:
  - refresh_req is high exactly 1 cycle, then ready=1.
  - All strobes stay 0 throughout.
- First-pass stream: 4 back-to-back beats, lane0 = 1..4, pass_first=1.
  - No adder_pulse.
  - feature_valid_out for 4 cycles starting 4 cycles after the first beat, lane0 = 1,2,3,4.
- Accumulate pass: adder_feature model returns 10,20,30,40 for lanes 0–3 with 3-cycle latency; mac lanes = 5.
  - adder_pulse coincides with each beat.
  - feature_out lanes = 15,25,35,45.
- Saturation:
  - mac = 2^35-1 with feedback 1 -> lane = 34359738367, sat_flag=1.
  - mac = -2^35 with feedback -1 -> lane = -34359738368.
- pass_start with 3 beats in flight:
  - DRAIN, ready=0 until the last write-back, then one refresh_req cycle, then ready=1.
  - A beat sent during DRAIN sets drop_flag and produces no output.
- Last pass, pass_last=1, feedback 7, mac 3:
  - final_valid with lane = 10 at latency 4.
  - feature_valid_out stays 0.
- Separately, assert rst_n mid-stream -> no further strobes.

Source files
------------

// File: rtl/psum_accumulator_pkg.sv
// Shared widths, latencies and saturation bounds for the partial-sum accumulator.
// The FSM state type lives here so the top and any debug tooling agree on encoding.
package psum_accumulator_pkg;

    localparam int MAC_OUTPUT_WIDTH    = 36;
    localparam int LANES               = 8;
    localparam int BUFFER_READ_LATENCY = 3;
    localparam int BUS_WIDTH           = MAC_OUTPUT_WIDTH * LANES;

    localparam logic [MAC_OUTPUT_WIDTH-1:0] SAT_MAX = {1'b0, {(MAC_OUTPUT_WIDTH-1){1'b1}}};
    localparam logic [MAC_OUTPUT_WIDTH-1:0] SAT_MIN = {1'b1, {(MAC_OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_DRAIN,
        ST_REFRESH
    } state_t;

endpackage

// File: rtl/psum_accumulator_if.sv
// Beat, buffer read-back, write-back and final-sum signals between the accumulator
// and its neighbours; slave is the accumulator's view, master the surrounding logic's.
interface psum_accumulator_if;
    import psum_accumulator_pkg::*;

    logic                 pass_start;
    logic [BUS_WIDTH-1:0] mac_data;
    logic                 mac_valid;
    logic                 pass_first;
    logic                 pass_last;
    logic                 ready;
    logic                 refresh_req;
    logic                 adder_pulse;
    logic [BUS_WIDTH-1:0] adder_feature;
    logic [BUS_WIDTH-1:0] feature_out;
    logic                 feature_valid_out;
    logic [BUS_WIDTH-1:0] final_data;
    logic                 final_valid;
    logic                 sat_flag;
    logic                 drop_flag;

    modport slave (
        input  pass_start, mac_data, mac_valid, pass_first, pass_last, adder_feature,
        output ready, refresh_req, adder_pulse, feature_out, feature_valid_out,
               final_data, final_valid, sat_flag, drop_flag
    );

    modport master (
        output pass_start, mac_data, mac_valid, pass_first, pass_last, adder_feature,
        input  ready, refresh_req, adder_pulse, feature_out, feature_valid_out,
               final_data, final_valid, sat_flag, drop_flag
    );

endinterface

// File: rtl/psum_accumulator_sat_add.sv
// One lane of signed MAC + read-back add, clamped to the lane range.
// Bypass forces a zero addend for first-pass beats that have no stored partial sum.
module psum_sat_add
    import psum_accumulator_pkg::*;
(
    input  logic [MAC_OUTPUT_WIDTH-1:0] mac_i,
    input  logic [MAC_OUTPUT_WIDTH-1:0] feedback_i,
    input  logic                        bypass_i,
    output logic [MAC_OUTPUT_WIDTH-1:0] sum_o,
    output logic                        sat_o
);

    logic [MAC_OUTPUT_WIDTH-1:0] addend;
    logic [MAC_OUTPUT_WIDTH:0]   wideSum;

    // Overflow shows up as the two top bits of the one-bit-wider sum disagreeing
    always_comb begin
        addend  = bypass_i ? '0 : feedback_i;
        wideSum = {mac_i[MAC_OUTPUT_WIDTH-1], mac_i} + {addend[MAC_OUTPUT_WIDTH-1], addend};
        sat_o   = wideSum[MAC_OUTPUT_WIDTH] ^ wideSum[MAC_OUTPUT_WIDTH-1];
        sum_o   = wideSum[MAC_OUTPUT_WIDTH-1:0];
        if (sat_o) begin
            sum_o = wideSum[MAC_OUTPUT_WIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Read-modify-write stage ahead of the conv output buffer: adds MAC beats to the read-back
// partial sums and either writes them back or, on the last pass, emits them downstream.
module psum_accumulator
    import psum_accumulator_pkg::*;
(
    input  logic               system_clk,
    input  logic               rst_n,
    psum_accumulator_if.slave  bus
);

    localparam int LAT = BUFFER_READ_LATENCY;

    state_t               state_q, state_d;
    logic                 accept;
    logic                 pipeEmpty;
    logic                 enterRefresh;
    logic [LAT-1:0]       valid_q, first_q, last_q;
    logic [BUS_WIDTH-1:0] data_q [LAT];
    logic [BUS_WIDTH-1:0] sumBus;
    logic [LANES-1:0]     laneSat;
    logic [BUS_WIDTH-1:0] featureOut_q, finalData_q;
    logic                 featureValid_q, finalValid_q;
    logic                 satFlag_q, dropFlag_q;

    assign pipeEmpty    = ~|valid_q;
    assign accept       = bus.mac_valid & (state_q == ST_ACCEPT);
    assign enterRefresh = (state_d == ST_REFRESH) && (state_q != ST_REFRESH);

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ACCEPT;
        else        state_q <= state_d;
    end

    // A beat arriving alongside pass_start still belongs to the old pass, so it forces a drain
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT:  if (bus.pass_start) state_d = (pipeEmpty && !bus.mac_valid) ? ST_REFRESH : ST_DRAIN;
            ST_DRAIN:   if (pipeEmpty) state_d = ST_REFRESH;
            ST_REFRESH: state_d = ST_ACCEPT;
            default:    state_d = ST_ACCEPT;
        endcase
    end

    assign bus.ready       = (state_q == ST_ACCEPT);
    assign bus.refresh_req = (state_q == ST_REFRESH);
    assign bus.adder_pulse = accept & ~bus.pass_first;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            first_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= {valid_q[LAT-2:0], accept};
            first_q <= {first_q[LAT-2:0], bus.pass_first};
            last_q  <= {last_q[LAT-2:0],  bus.pass_last};
        end
    end

    always_ff @(posedge system_clk) begin
        data_q[0] <= bus.mac_data;
        for (int i = 1; i < LAT; i++) data_q[i] <= data_q[i-1];
    end

    for (genvar i = 0; i < LANES; i++) begin : gen_lane
        psum_sat_add u_sat_add (
            .mac_i      (data_q[LAT-1][i*MAC_OUTPUT_WIDTH +: MAC_OUTPUT_WIDTH]),
            .feedback_i (bus.adder_feature[i*MAC_OUTPUT_WIDTH +: MAC_OUTPUT_WIDTH]),
            .bypass_i   (first_q[LAT-1]),
            .sum_o      (sumBus[i*MAC_OUTPUT_WIDTH +: MAC_OUTPUT_WIDTH]),
            .sat_o      (laneSat[i])
        );
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            featureValid_q <= 1'b0;
            finalValid_q   <= 1'b0;
            featureOut_q   <= '0;
            finalData_q    <= '0;
        end else begin
            featureValid_q <= valid_q[LAT-1] & ~last_q[LAT-1];
            finalValid_q   <= valid_q[LAT-1] &  last_q[LAT-1];
            if (valid_q[LAT-1] && !last_q[LAT-1]) featureOut_q <= sumBus;
            if (valid_q[LAT-1] &&  last_q[LAT-1]) finalData_q  <= sumBus;
        end
    end

    // Sticky flags are scoped to one pass, so the refresh between passes clears them
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            satFlag_q  <= 1'b0;
            dropFlag_q <= 1'b0;
        end else if (enterRefresh) begin
            satFlag_q  <= 1'b0;
            dropFlag_q <= 1'b0;
        end else begin
            if (valid_q[LAT-1] && (|laneSat))               satFlag_q  <= 1'b1;
            if (bus.mac_valid && (state_q != ST_ACCEPT))    dropFlag_q <= 1'b1;
        end
    end

    assign bus.feature_out       = featureOut_q;
    assign bus.feature_valid_out = featureValid_q;
    assign bus.final_data        = finalData_q;
    assign bus.final_valid       = finalValid_q;
    assign bus.sat_flag          = satFlag_q;
    assign bus.drop_flag         = dropFlag_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator with a 3-cycle buffer read-back model.
// Write-back and final strobes are captured with their cycle stamp and checked against hand-computed values.
module tb_psum_accumulator;
    import psum_accumulator_pkg::*;

    localparam int W  = MAC_OUTPUT_WIDTH;
    localparam int BW = BUS_WIDTH;

    typedef struct {
        int            cyc;
        logic [BW-1:0] data;
    } beat_t;

    logic system_clk = 1'b0;
    logic rst_n      = 1'b0;

    psum_accumulator_if bus();

    psum_accumulator dut (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    always #5 system_clk = ~system_clk;

    int            checks     = 0;
    int            failures   = 0;
    int            cyc        = 0;
    int            pulseCount = 0;
    logic          pulseSeen  = 1'b0;
    beat_t         featQ[$];
    beat_t         finalQ[$];
    beat_t         capT;
    logic [BW-1:0] fbQ[$];
    logic [BW-1:0] fbPipe[3] = '{default: '0};

    always @(posedge system_clk) cyc++;

    // Outputs are observed mid-cycle, well away from the active edge
    always @(negedge system_clk) begin
        pulseSeen = bus.adder_pulse;
        if (bus.adder_pulse) pulseCount++;
        if (bus.feature_valid_out) begin
            capT.cyc  = cyc;
            capT.data = bus.feature_out;
            featQ.push_back(capT);
        end
        if (bus.final_valid) begin
            capT.cyc  = cyc;
            capT.data = bus.final_data;
            finalQ.push_back(capT);
        end
    end

    // Buffer model: the value queued for a read appears on adder_feature three cycles after its pulse
    always @(posedge system_clk) begin
        #1;
        fbPipe[2] = fbPipe[1];
        fbPipe[1] = fbPipe[0];
        fbPipe[0] = '0;
        if (pulseSeen && fbQ.size() > 0) fbPipe[0] = fbQ.pop_front();
        bus.adder_feature = fbPipe[2];
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [BW-1:0] setLane(input logic [BW-1:0] b, input int i, input longint v);
        b[i*W +: W] = v[W-1:0];
        return b;
    endfunction

    function automatic logic [BW-1:0] fillBus(input longint v);
        logic [BW-1:0] b = '0;
        for (int i = 0; i < LANES; i++) b[i*W +: W] = v[W-1:0];
        return b;
    endfunction

    function automatic longint laneOf(input logic [BW-1:0] b, input int i);
        logic signed [W-1:0] v;
        v = b[i*W +: W];
        return longint'(v);
    endfunction

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic first, input logic last,
                                 input logic start, input logic [BW-1:0] data);
        bus.mac_valid  = valid;
        bus.pass_first = first;
        bus.pass_last  = last;
        bus.pass_start = start;
        bus.mac_data   = data;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge system_clk);
            #2;
        end
    endtask

    task automatic clearCaptures();
        featQ.delete();
        finalQ.delete();
        pulseCount = 0;
    endtask

    initial begin
        int            c0;
        logic [BW-1:0] fb;

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        bus.adder_feature = '0;
        rst_n = 1'b0;
        tick(3);
        checkOutput("reset_feature_valid", bus.feature_valid_out, 0);
        checkOutput("reset_final_valid", bus.final_valid, 0);
        checkOutput("reset_refresh_req", bus.refresh_req, 0);
        checkOutput("reset_adder_pulse", bus.adder_pulse, 0);
        checkOutput("reset_sat_flag", bus.sat_flag, 0);
        checkOutput("reset_drop_flag", bus.drop_flag, 0);
        checkOutput("reset_feature_out", laneOf(bus.feature_out, 0), 0);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] pass_start with empty pipeline");
        clearCaptures();
        bus.pass_start = 1'b1;
        #1;
        checkOutput("idle_ready", bus.ready, 1);
        tick(1);
        bus.pass_start = 1'b0;
        #1;
        checkOutput("idle_refresh_high", bus.refresh_req, 1);
        checkOutput("idle_refresh_ready", bus.ready, 0);
        tick(1);
        checkOutput("idle_refresh_low", bus.refresh_req, 0);
        checkOutput("idle_ready_back", bus.ready, 1);
        tick(3);
        checkOutput("idle_no_strobes", featQ.size() + finalQ.size() + pulseCount, 0);

        $display("[TB] first-pass stream");
        clearCaptures();
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, setLane('0, 0, i + 1));
            #1;
            checkOutput("first_pulse", bus.adder_pulse, 0);
            tick(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(8);
        checkOutput("first_pulse_count", pulseCount, 0);
        checkOutput("first_write_count", featQ.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < featQ.size()) begin
                checkOutput("first_write_cycle", featQ[i].cyc, c0 + i + 4);
                checkOutput("first_write_lane0", laneOf(featQ[i].data, 0), i + 1);
            end
        end

        $display("[TB] accumulate pass");
        clearCaptures();
        fb = '0;
        fb = setLane(fb, 0, 10);
        fb = setLane(fb, 1, 20);
        fb = setLane(fb, 2, 30);
        fb = setLane(fb, 3, 40);
        fbQ.push_back(fb);
        fbQ.push_back(fb);
        c0 = cyc;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, fillBus(5));
            #1;
            checkOutput("acc_pulse", bus.adder_pulse, 1);
            tick(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(8);
        checkOutput("acc_write_count", featQ.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (i < featQ.size()) begin
                checkOutput("acc_write_cycle", featQ[i].cyc, c0 + i + 4);
                checkOutput("acc_lane0", laneOf(featQ[i].data, 0), 15);
                checkOutput("acc_lane1", laneOf(featQ[i].data, 1), 25);
                checkOutput("acc_lane2", laneOf(featQ[i].data, 2), 35);
                checkOutput("acc_lane3", laneOf(featQ[i].data, 3), 45);
                checkOutput("acc_lane4", laneOf(featQ[i].data, 4), 5);
            end
        end
        checkOutput("acc_sat_flag", bus.sat_flag, 0);

        $display("[TB] saturation");
        clearCaptures();
        fbQ.push_back(fillBus(1));
        fbQ.push_back(fillBus(-1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, fillBus(64'sd34359738367));
        tick(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, fillBus(-64'sd34359738368));
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(8);
        checkOutput("sat_write_count", featQ.size(), 2);
        if (featQ.size() == 2) begin
            checkOutput("sat_pos_lane0", laneOf(featQ[0].data, 0), 64'sd34359738367);
            checkOutput("sat_pos_lane7", laneOf(featQ[0].data, 7), 64'sd34359738367);
            checkOutput("sat_neg_lane0", laneOf(featQ[1].data, 0), -64'sd34359738368);
            checkOutput("sat_neg_lane7", laneOf(featQ[1].data, 7), -64'sd34359738368);
        end
        checkOutput("sat_flag_set", bus.sat_flag, 1);

        $display("[TB] pass_start with beats in flight");
        clearCaptures();
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, (k == 2), setLane('0, 0, 100 + k));
            tick(1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, fillBus(9));
        #1;
        checkOutput("drain_ready", bus.ready, 0);
        checkOutput("drain_drop_pulse", bus.adder_pulse, 0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 4; k < 10; k++) begin
            checkOutput("drain_ready_seq", bus.ready, (k >= 8) ? 1 : 0);
            checkOutput("drain_refresh_seq", bus.refresh_req, (k == 7) ? 1 : 0);
            if (k == 5) checkOutput("drain_drop_set", bus.drop_flag, 1);
            if (k == 7) checkOutput("drain_drop_cleared", bus.drop_flag, 0);
            if (k == 8) checkOutput("drain_sat_cleared", bus.sat_flag, 0);
            tick(1);
        end
        tick(2);
        checkOutput("drain_write_count", featQ.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < featQ.size()) begin
                checkOutput("drain_write_cycle", featQ[k].cyc, c0 + k + 4);
                checkOutput("drain_write_lane0", laneOf(featQ[k].data, 0), 100 + k);
            end
        end
        checkOutput("drain_pulse_count", pulseCount, 0);

        $display("[TB] last pass");
        clearCaptures();
        fbQ.push_back(fillBus(7));
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, fillBus(3));
        #1;
        checkOutput("last_pulse", bus.adder_pulse, 1);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, fillBus(9));
        #1;
        checkOutput("firstlast_pulse", bus.adder_pulse, 0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(8);
        checkOutput("last_no_writeback", featQ.size(), 0);
        checkOutput("last_final_count", finalQ.size(), 2);
        if (finalQ.size() == 2) begin
            checkOutput("last_final_cycle", finalQ[0].cyc, c0 + 4);
            checkOutput("last_final_lane0", laneOf(finalQ[0].data, 0), 10);
            checkOutput("last_final_lane7", laneOf(finalQ[0].data, 7), 10);
            checkOutput("firstlast_cycle", finalQ[1].cyc, c0 + 5);
            checkOutput("firstlast_lane0", laneOf(finalQ[1].data, 0), 9);
        end

        $display("[TB] reset mid-stream");
        clearCaptures();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, (k == 1), 1'b0, fillBus(k + 1));
            tick(1);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(8);
        checkOutput("midreset_no_strobes", featQ.size() + finalQ.size(), 0);
        checkOutput("midreset_ready", bus.ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
